// File: rtl/mem1port_arbiter.sv
// -----------------------------------------------------------------------------
// mem1port_arbiter
//   Two-master arbiter in front of the single-port memory (mem1port). It merges
//   the core's instruction fetch (imem, read-only) and data (dmem, read/write)
//   requests onto one memory port. It remembers which master owns the read that
//   is in flight and routes the memory's one-cycle-later response back to it.
//
//   Build option: define ARB_RR_EN to select round-robin arbitration. The
//   default build uses fixed dmem priority. In that mode a starvation counter
//   forces an imem grant after STARVE_MAX-1 consecutive lost cycles.
//
// Parameters
//   STARVE_MAX  consecutive imem wait cycles before imem is forced (>=1)
//   CNT_W       width of the performance counters
//
// Ports
//   clk, resetb            clock; asynchronous active-low reset
//   i_req/i_addr           imem read request (held until i_gnt)
//   i_gnt                  imem accepted this cycle (combinational)
//   i_rvalid/i_rdata       imem read response
//   d_req/d_we/d_addr/
//   d_wdata/d_wstrb        dmem request (held until d_gnt)
//   d_gnt                  dmem accepted this cycle (combinational)
//   d_rvalid/d_rdata       dmem read response
//   m_ready/m_we/m_addr/
//   m_wdata/m_wstrb        memory access driven from the winner
//   m_rresp/m_rdata        registered memory read response
//   cnt_i/cnt_d/cnt_conf   imem grants, dmem grants, conflict cycles
// -----------------------------------------------------------------------------
module mem1port_arbiter #(
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             i_req,
  input  logic [29:0]      i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [31:0]      i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [29:0]      d_addr,
  input  logic [31:0]      d_wdata,
  input  logic [3:0]       d_wstrb,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             m_ready,
  output logic             m_we,
  output logic [29:0]      m_addr,
  output logic [31:0]      m_wdata,
  output logic [3:0]       m_wstrb,
  input  logic             m_rresp,
  input  logic [31:0]      m_rdata,
  output logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] cnt_d,
  output logic [CNT_W-1:0] cnt_conf
);

  // Arbitration result before reset gating. The arbitration state registers
  // are held in reset whenever resetb is low. Their next-state logic can
  // therefore use i_win directly, which avoids a combinational path back
  // through i_gnt.
  logic i_win;

  logic owner_reg, owner_next;   // 0 = imem owns the read in flight, 1 = dmem
  logic pend_reg, pend_next;     // a read was granted last cycle
  logic rd_gnt;

`ifdef ARB_RR_EN
  logic last_reg, last_next;     // winner of the most recent grant (0 = imem)

  always_comb begin
    i_win     = i_req & (~d_req | last_reg);
    last_next = last_reg;
    if (i_win)
      last_next = 1'b0;
    else if (d_req)
      last_next = 1'b1;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)
      last_reg <= 1'b0;
    else
      last_reg <= last_next;
  end
`else
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
  logic          starve_hit;

  // The counter stops at STARVE_LAST. At that value imem is forced through,
  // and the grant clears the counter, so it cannot wrap.
  always_comb begin
    starve_hit      = (starve_cnt_reg == STARVE_LAST);
    i_win           = i_req & (~d_req | starve_hit);
    starve_cnt_next = starve_cnt_reg;
    if (!i_req || i_win)
      starve_cnt_next = '0;
    else if (!starve_hit)
      starve_cnt_next = starve_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)
      starve_cnt_reg <= '0;
    else
      starve_cnt_reg <= starve_cnt_next;
  end
`endif

  assign i_gnt   = resetb & i_win;
  assign d_gnt   = resetb & d_req & ~i_win;
  assign m_ready = i_gnt | d_gnt;
  assign m_we    = d_gnt & d_we;
  assign m_addr  = i_gnt ? i_addr : d_addr;
  assign m_wdata = d_wdata;
  assign m_wstrb = i_gnt ? 4'b0000 : d_wstrb;

  // Only reads move ownership. A write granted right after a read leaves the
  // routing of that read's response unchanged.
  assign rd_gnt     = i_gnt | (d_gnt & ~d_we);
  assign owner_next = rd_gnt ? d_gnt : owner_reg;
  assign pend_next  = rd_gnt;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      owner_reg <= 1'b0;
      pend_reg  <= 1'b0;
    end else begin
      owner_reg <= owner_next;
      pend_reg  <= pend_next;
    end
  end

  // pend_reg drops a response whose read was issued before a reset. This holds
  // even when the memory still presents m_rresp after a short reset pulse.
  assign i_rvalid = resetb & m_rresp & pend_reg & ~owner_reg;
  assign d_rvalid = resetb & m_rresp & pend_reg & owner_reg;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

  // Performance counters: 0 = imem grants, 1 = dmem grants, 2 = conflicts.
  logic [2:0]            cnt_inc;
  logic [2:0][CNT_W-1:0] cnt_bus;

  assign cnt_inc = {i_req & d_req, d_gnt, i_gnt};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb)
        cnt_reg <= '0;
      else if (cnt_inc[gi])
        cnt_reg <= cnt_reg + 1'b1;
    end

    assign cnt_bus[gi] = cnt_reg;
  end

  assign cnt_i    = cnt_bus[0];
  assign cnt_d    = cnt_bus[1];
  assign cnt_conf = cnt_bus[2];

endmodule

// File: tb/tb_mem1port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem1port_arbiter
//   Self-checking bench for mem1port_arbiter. It contains a behavioural
//   single-port memory with a registered read. A scoreboard records each
//   read grant and the expected data, and checks the owner and data of each
//   response. Scenario tasks run in sequence from one initial block.
//   Memory word contents are pat(addr) until the bench writes them.
// -----------------------------------------------------------------------------
module tb_mem1port_arbiter;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             resetb;
  logic             i_req;
  logic [29:0]      i_addr;
  logic             i_gnt, i_rvalid;
  logic [31:0]      i_rdata;
  logic             d_req, d_we;
  logic [29:0]      d_addr;
  logic [31:0]      d_wdata;
  logic [3:0]       d_wstrb;
  logic             d_gnt, d_rvalid;
  logic [31:0]      d_rdata;
  logic             m_ready, m_we;
  logic [29:0]      m_addr;
  logic [31:0]      m_wdata;
  logic [3:0]       m_wstrb;
  logic             m_rresp = 1'b0;
  logic [31:0]      m_rdata = '0;
  logic [CNT_W-1:0] cnt_i, cnt_d, cnt_conf;

  mem1port_arbiter #(.STARVE_MAX(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetb(resetb),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rresp(m_rresp), .m_rdata(m_rdata),
    .cnt_i(cnt_i), .cnt_d(cnt_d), .cnt_conf(cnt_conf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int a);
    if (a == 4) return 32'hDEADBEEF;
    return 32'hC0DE0000 ^ (32'(a) * 32'h01010101);
  endfunction

  // ---------------- memory model: registered read, byte-strobed write -------
  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= pat(k);
      mem_init <= 1'b1;
    end else if (m_ready && m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_wstrb[b]) mem[m_addr[7:0]][8*b +: 8] <= m_wdata[8*b +: 8];
    end
    m_rresp <= m_ready & ~m_we;
    m_rdata <= mem[m_addr[7:0]];
  end

  // ---------------- scoreboard --------------------------------------------
  typedef struct {
    int          due;
    logic        master;   // 0 = imem, 1 = dmem
    logic [31:0] data;
  } sb_t;

  sb_t         sb[$];
  sb_t         sb_e;
  logic [31:0] ref_mem [int];
  logic [31:0] ref_w;
  logic [31:0] got_data;
  int          ref_a;

  always @(negedge clk) begin
    if (!resetb) begin
      sb.delete();
    end else begin
      if (i_rvalid || d_rvalid) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: i_rvalid=%b d_rvalid=%b, required no response", i_rvalid, d_rvalid);
        end else begin
          sb_e     = sb.pop_front();
          got_data = sb_e.master ? d_rdata : i_rdata;
          if ((i_rvalid && d_rvalid) || d_rvalid !== sb_e.master || got_data !== sb_e.data || sb_e.due != cyc)
            $display("FAIL sb_resp: i_rvalid=%b d_rvalid=%b data=%h cyc=%0d, required master=%0d data=%h cyc=%0d",
                     i_rvalid, d_rvalid, got_data, cyc, sb_e.master, sb_e.data, sb_e.due);
          else
            n_pass++;
          $display("cyc %0d resp %s data=%h", cyc, d_rvalid ? "dmem" : "imem", got_data);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_checks++;
        sb_e = sb.pop_front();
        $display("FAIL sb_missing: no rvalid at cyc %0d, required master=%0d data=%h", cyc, sb_e.master, sb_e.data);
      end

      if (i_gnt) begin
        ref_a = int'(i_addr[7:0]);
        sb.push_back('{due: cyc + 1, master: 1'b0, data: ref_mem.exists(ref_a) ? ref_mem[ref_a] : pat(ref_a)});
        $display("cyc %0d grant imem rd addr=%h", cyc, i_addr);
      end else if (d_gnt && !d_we) begin
        ref_a = int'(d_addr[7:0]);
        sb.push_back('{due: cyc + 1, master: 1'b1, data: ref_mem.exists(ref_a) ? ref_mem[ref_a] : pat(ref_a)});
        $display("cyc %0d grant dmem rd addr=%h", cyc, d_addr);
      end else if (d_gnt && d_we) begin
        ref_a = int'(d_addr[7:0]);
        ref_w = ref_mem.exists(ref_a) ? ref_mem[ref_a] : pat(ref_a);
        for (int b = 0; b < 4; b++)
          if (d_wstrb[b]) ref_w[8*b +: 8] = d_wdata[8*b +: 8];
        ref_mem[ref_a] = ref_w;
        $display("cyc %0d grant dmem wr addr=%h data=%h strb=%b", cyc, d_addr, d_wdata, d_wstrb);
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = 4'hF;
  endtask

  task automatic do_reset;
    idle_inputs();
    resetb = 1'b0;
    next_cycle();
    next_cycle();
    resetb = 1'b1;
    next_cycle();
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset;
    resetb = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    @(negedge clk);
    n_checks++; if (i_gnt !== 1'b0)    $display("FAIL rst_i_gnt: got %b want 0", i_gnt); else n_pass++;
    n_checks++; if (d_gnt !== 1'b0)    $display("FAIL rst_d_gnt: got %b want 0", d_gnt); else n_pass++;
    n_checks++; if (m_ready !== 1'b0)  $display("FAIL rst_m_ready: got %b want 0", m_ready); else n_pass++;
    n_checks++; if (m_we !== 1'b0)     $display("FAIL rst_m_we: got %b want 0", m_we); else n_pass++;
    n_checks++; if ({i_rvalid, d_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {i_rvalid, d_rvalid}); else n_pass++;
    n_checks++; if ({cnt_i, cnt_d, cnt_conf} !== '0) $display("FAIL rst_cnt: got %0d/%0d/%0d want 0/0/0", cnt_i, cnt_d, cnt_conf); else n_pass++;
    next_cycle();
    do_reset();
  endtask

  // imem read of byte address 0x10 (word 4), which holds 0xDEADBEEF.
  task automatic test_imem_read;
    idle_inputs();
    i_req = 1'b1; i_addr = 30'h4;
    @(negedge clk);
    n_checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) $display("FAIL i1_gnt: got i=%b d=%b want i=1 d=0", i_gnt, d_gnt); else n_pass++;
    n_checks++; if (m_ready !== 1'b1 || m_addr !== 30'h4) $display("FAIL i1_maddr: got ready=%b addr=%h want 1/4", m_ready, m_addr); else n_pass++;
    n_checks++; if (m_we !== 1'b0 || m_wstrb !== 4'b0000) $display("FAIL i1_mwe: got we=%b strb=%b want 0/0000", m_we, m_wstrb); else n_pass++;
    next_cycle();
    i_req = 1'b0;
    @(negedge clk);
    n_checks++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0) $display("FAIL i1_rvalid: got i=%b d=%b want i=1 d=0", i_rvalid, d_rvalid); else n_pass++;
    n_checks++; if (i_rdata !== 32'hDEADBEEF) $display("FAIL i1_rdata: got %h want deadbeef", i_rdata); else n_pass++;
    next_cycle();
  endtask

  // dmem write to byte address 0x20 (word 8), low halfword only, then read back.
  task automatic test_dmem_write_read;
    logic [31:0] old_w;
    old_w = pat(8);
    idle_inputs();
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h8; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
    @(negedge clk);
    n_checks++; if (d_gnt !== 1'b1 || m_we !== 1'b1) $display("FAIL d2_wr: got gnt=%b we=%b want 1/1", d_gnt, m_we); else n_pass++;
    n_checks++; if (m_wstrb !== 4'b0011 || m_wdata !== 32'h12345678 || m_addr !== 30'h8)
      $display("FAIL d2_wfields: got strb=%b data=%h addr=%h want 0011/12345678/8", m_wstrb, m_wdata, m_addr); else n_pass++;
    next_cycle();
    d_we = 1'b0; d_wdata = '0;
    @(negedge clk);
    n_checks++; if (d_gnt !== 1'b1 || m_we !== 1'b0) $display("FAIL d2_rd: got gnt=%b we=%b want 1/0", d_gnt, m_we); else n_pass++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0) $display("FAIL d2_rvalid: got d=%b i=%b want 1/0", d_rvalid, i_rvalid); else n_pass++;
    n_checks++; if (d_rdata[15:0] !== 16'h5678 || d_rdata[31:16] !== old_w[31:16])
      $display("FAIL d2_rdata: got %h want %h5678", d_rdata, old_w[31:16]); else n_pass++;
    next_cycle();
  endtask

  // Both masters request reads for 20 cycles starting from reset state.
  task automatic test_conflict;
    logic exp_i;
    int   exp_ci;
    do_reset();
    i_req = 1'b1; i_addr = 30'h3;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h5;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
`ifdef ARB_RR_EN
      exp_i = (k % 2) == 1;
`else
      exp_i = (k % 8) == 7;
`endif
      n_checks++;
      if (i_gnt !== exp_i || d_gnt !== !exp_i)
        $display("FAIL conf_gnt[%0d]: got i=%b d=%b want i=%b d=%b", k, i_gnt, d_gnt, exp_i, !exp_i);
      else n_pass++;
      next_cycle();
    end
    idle_inputs();
`ifdef ARB_RR_EN
    exp_ci = 10;
`else
    exp_ci = 2;
`endif
    @(negedge clk);
    n_checks++; if (cnt_conf !== 32'd20) $display("FAIL conf_cnt_conf: got %0d want 20", cnt_conf); else n_pass++;
    n_checks++; if (cnt_i !== CNT_W'(exp_ci) || cnt_d !== CNT_W'(20 - exp_ci))
      $display("FAIL conf_cnt_id: got i=%0d d=%0d want i=%0d d=%0d", cnt_i, cnt_d, exp_ci, 20 - exp_ci); else n_pass++;
    next_cycle();
  endtask

  // imem read at N, dmem read at N+1, then imem read followed by a dmem write.
  task automatic test_back_to_back;
    logic [31:0] e1, e2;
    e1 = pat(1); e2 = pat(2);
    idle_inputs();
    i_req = 1'b1; i_addr = 30'h1;
    @(negedge clk);
    n_checks++; if (i_gnt !== 1'b1) $display("FAIL b2b_i_gnt: got %b want 1", i_gnt); else n_pass++;
    next_cycle();
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 30'h2;
    @(negedge clk);
    n_checks++; if (d_gnt !== 1'b1) $display("FAIL b2b_d_gnt: got %b want 1", d_gnt); else n_pass++;
    n_checks++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== e1)
      $display("FAIL b2b_i_resp: got i=%b d=%b data=%h want 1/0/%h", i_rvalid, d_rvalid, i_rdata, e1); else n_pass++;
    next_cycle();
    idle_inputs();
    i_req = 1'b1; i_addr = 30'h3;
    @(negedge clk);
    n_checks++; if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== e2)
      $display("FAIL b2b_d_resp: got d=%b i=%b data=%h want 1/0/%h", d_rvalid, i_rvalid, d_rdata, e2); else n_pass++;
    next_cycle();
    idle_inputs();
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h9; d_wdata = 32'hCAFEF00D; d_wstrb = 4'hF;
    @(negedge clk);
    n_checks++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0) $display("FAIL b2b_wr_route: got i=%b d=%b want 1/0", i_rvalid, d_rvalid); else n_pass++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++; if ({i_rvalid, d_rvalid} !== 2'b00) $display("FAIL b2b_wr_noresp: got %b want 00", {i_rvalid, d_rvalid}); else n_pass++;
    next_cycle();
  endtask

  // Reset after a read grant: the response is dropped, state clears and the
  // next request proceeds normally. Also checks a short asynchronous pulse.
  task automatic test_reset_midop;
    idle_inputs();
    i_req = 1'b1; i_addr = 30'h6;
    @(negedge clk);
    n_checks++; if (i_gnt !== 1'b1) $display("FAIL rm_gnt: got %b want 1", i_gnt); else n_pass++;
    next_cycle();
    idle_inputs();
    resetb = 1'b0;
    @(negedge clk);
    n_checks++; if ({i_rvalid, d_rvalid} !== 2'b00) $display("FAIL rm_rvalid: got %b want 00", {i_rvalid, d_rvalid}); else n_pass++;
    n_checks++; if ({cnt_i, cnt_d, cnt_conf} !== '0) $display("FAIL rm_cnt: got %0d/%0d/%0d want 0", cnt_i, cnt_d, cnt_conf); else n_pass++;
    next_cycle();
    resetb = 1'b1;
    @(negedge clk);
    n_checks++; if ({i_rvalid, d_rvalid} !== 2'b00) $display("FAIL rm_rvalid2: got %b want 00", {i_rvalid, d_rvalid}); else n_pass++;
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h7;
    @(negedge clk);
    n_checks++; if (d_gnt !== 1'b1 || m_addr !== 30'h7) $display("FAIL rm_regrant: got gnt=%b addr=%h want 1/7", d_gnt, m_addr); else n_pass++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (cnt_d !== 32'd1 || cnt_i !== 32'd0) $display("FAIL rm_cnt_after: got d=%0d i=%0d want 1/0", cnt_d, cnt_i); else n_pass++;
    next_cycle();
    // A short pulse between a grant and its response still drops the response.
    i_req = 1'b1; i_addr = 30'h4;
    @(negedge clk);
    @(posedge clk);
    #1 idle_inputs(); resetb = 1'b0;
    #1 resetb = 1'b1;
    sb.delete();
    @(negedge clk);
    n_checks++; if ({i_rvalid, d_rvalid} !== 2'b00) $display("FAIL rm_pulse_drop: got %b want 00", {i_rvalid, d_rvalid}); else n_pass++;
    n_checks++; if (cnt_i !== 32'd0) $display("FAIL rm_pulse_cnt: got %0d want 0", cnt_i); else n_pass++;
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    resetb = 1'b0;
    next_cycle();
    test_reset();
    test_imem_read();
    test_dmem_write_read();
    test_back_to_back();
    test_conflict();
    test_reset_midop();
    next_cycle();
    next_cycle();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
